adder_pipe_full: RTL and testbench
==================================

Name: adder_pipe_full

Overview:
- Parametrised, pipelined N-bit ripple adder/subtractor; successor to the single-bit full adder cell.
- Splits the operand into STAGES equal chunks. Each chunk is added in its own register stage, and the carry is passed stage to stage.
- Valid/ready handshake on input and output; sits between operand sources and multiplier/accumulator datapaths in the arithmetic test designs.

Parameters:
- WIDTH, 16, operand and result width in bits.
- STAGES, 4, pipeline depth and chunk count. Legal values: 1..WIDTH, with WIDTH % STAGES == 0. Chunk width CW = WIDTH/STAGES.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- nRST  in  1  asynchronous active-low reset.
- IN_VALID  in  1  operand set valid.
- IN_READY  out  1  block accepts operands this cycle.
- A  in  WIDTH  operand A, unsigned/two's complement.
- B  in  WIDTH  operand B.
- CIN  in  1  carry-in; used only when SUB=0.
- SUB  in  1  0: A+B+CIN, 1: A-B (A + ~B + 1).
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  downstream accepts result.
- Q  out  WIDTH  sum/difference.
- COUT  out  1  carry-out of the MSB. In subtract mode COUT = NOT borrow (1 when A >= B unsigned).

Behaviour:
- Reset (nRST=0, async): all stage valid bits = 0, all data/carry registers = 0. Resulting output values: OUT_VALID=0, Q=0, COUT=0. IN_READY follows the combinational rule below (=1 while in reset).
- Advance signal: ADV = ~OUT_VALID | OUT_READY. IN_READY = ADV (combinational).
- Pipeline moves only when ADV=1; with ADV=0 every stage register holds its value.
- Transfer in: IN_VALID & IN_READY. Transfer out: OUT_VALID & OUT_READY.
- Operand preparation at stage 0 input: B' = SUB ? ~B : B; c0 = SUB ? 1 : CIN.
- Stage k (0..STAGES-1):
  - Computes chunk k: {c, s} = A[k] + B'[k] + carry_k, where carry_0 = c0 and carry_k = the registered carry from stage k-1.
  - Upper operand chunks (>k) travel skewed, delayed one register per stage.
  - Finished lower result chunks (<=k) travel alongside.
- Each stage holds one valid bit; stage k valid loads stage k-1 valid when ADV=1. Stage 0 valid loads IN_VALID & IN_READY.
- Bubbles are not collapsed.
- Latency: exactly STAGES cycles from input transfer to OUT_VALID, if no stall.
- Throughput: 1 result/cycle while OUT_READY=1.
- Q, COUT and OUT_VALID are registered outputs of the last stage. They are stable while OUT_VALID=1 and OUT_READY=0.
- STAGES=1: single registered adder, latency 1.
- Wrap-around: results are modulo 2^WIDTH. The carry beyond COUT is discarded.
- IN_VALID=0 while IN_READY=1: a bubble (valid=0) enters. Data registers may update, but their contents are don't-care.
- Simultaneous input and output transfer in the same cycle: both complete, with no loss or duplication.
- Reset asserted mid-operation: all in-flight results are discarded immediately. No output transfer occurs in the cycle reset is released.
- SUB is sampled with the operands and travels with them. Mixed add/sub streams are legal back-to-back.

Optional Feature:
- Macro: ADDER_PIPE_OVF_EN.
- Defined:
  - Adds output port OVF (1 bit), registered with the final stage and reset to 0.
  - OVF = signed two's-complement overflow: carry into the MSB XOR carry out of the MSB, using the effective B' and c0.
- Undefined:
  - The OVF port does not exist; there is no MSB-internal carry tap and no extra register.

Test Plan (WIDTH=16, STAGES=4):
- A=0xFFFF, B=0x0001, CIN=0, SUB=0, OUT_READY=1 -> 4 cycles later OUT_VALID=1 for one cycle, Q=0x0000, COUT=1.
- A=0x0005, B=0x0007, SUB=1 -> Q=0xFFFE, COUT=0; then A=0x0007, B=0x0005, SUB=1 -> Q=0x0002, COUT=1.
- Stream of 3 back-to-back ops (0x1234+0x1111, 0x00FF+0x0001 with CIN=1, 0x8000+0x8000) with OUT_READY=1 -> Q=0x2345/0; 0x0101/0; 0x0000/1 (Q/COUT) on consecutive cycles 4..6.
- Same stream, OUT_READY forced 0 for cycles 5-6 -> IN_READY=0 during stall, first result Q=0x2345 held stable, all three results delivered in order with none lost.
- Launch 2 ops, assert nRST at cycle 2 for one cycle -> OUT_VALID, Q and COUT go to 0 immediately; no result appears afterwards until new input.
- With ADDER_PIPE_OVF_EN: 0x7FFF+0x0001 -> Q=0x8000, OVF=1; 0x8000-0x0001 (SUB=1) -> Q=0x7FFF, OVF=1; 0x0003+0x0004 -> OVF=0.

Source files
------------

// File: rtl/adder_pipe_full.sv
// adder_pipe_full: pipelined N-bit ripple adder/subtractor with a valid/ready
// handshake. The operands are split into STAGES chunks of CW = WIDTH/STAGES
// bits. Stage k adds chunk k using the carry registered by stage k-1.
// Operand bits that are not yet consumed travel skewed beside the pipeline,
// and finished result chunks travel along with them.
//
// Parameters
//   WIDTH  : operand/result width (default 16)
//   STAGES : pipeline depth and chunk count, 1..WIDTH, WIDTH % STAGES == 0
//
// Ports
//   CLK       in   system clock, rising edge
//   nRST      in   asynchronous active-low reset
//   IN_VALID  in   operand set valid
//   IN_READY  out  operands accepted this cycle (combinational: ~OUT_VALID | OUT_READY)
//   A, B      in   operands, WIDTH bits
//   CIN       in   carry-in, ignored when SUB=1
//   SUB       in   0: A+B+CIN, 1: A-B computed as A + ~B + 1
//   OUT_VALID out  result valid (registered)
//   OUT_READY in   downstream accepts result
//   Q         out  sum/difference modulo 2^WIDTH (registered)
//   OVF       out  signed overflow, only when ADDER_PIPE_OVF_EN is defined (registered)
//   COUT      out  carry-out of the MSB; NOT borrow in subtract mode (registered)
//
// Optional feature macro: ADDER_PIPE_OVF_EN adds the OVF port and its register.

module adder_pipe_full #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    input  logic             SUB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] Q,
`ifdef ADDER_PIPE_OVF_EN
    output logic             OVF,
`endif
    output logic             COUT
);

    localparam int unsigned CW   = WIDTH / STAGES;
    localparam int unsigned SW   = CW + 1;
    localparam int unsigned LAST = STAGES - 1;

    logic             w_adv;
    logic [WIDTH-1:0] w_bp;
    logic             w_c0;

    // Whole pipeline advances together; a full last stage blocks everything.
    assign w_adv    = ~OUT_VALID | OUT_READY;
    assign IN_READY = w_adv;

    // Subtraction folded into the operand: A + ~B + 1.
    assign w_bp = SUB ? ~B : B;
    assign w_c0 = SUB ? 1'b1 : CIN;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // LO: bit position of this stage's chunk; BW: B' bits still pending here
        localparam int unsigned LO = k * CW;
        localparam int unsigned BW = WIDTH - LO;

        logic [WIDTH-1:0] w_x_src;   // finished chunks below LO, operand A at and above
        logic [BW-1:0]    w_b_src;   // B' chunks at and above LO
        logic             w_c_src;
        logic             w_v_src;
        logic [SW-1:0]    w_sum;
        logic [WIDTH-1:0] w_x_nxt;

        logic [WIDTH-1:0] r_x;
        logic             r_c;
        logic             r_valid;

        if (k == 0) begin : g_head
            assign w_x_src = A;
            assign w_b_src = w_bp;
            assign w_c_src = w_c0;
            assign w_v_src = IN_VALID;
        end else begin : g_tail
            assign w_x_src = g_stage[k-1].r_x;
            assign w_b_src = g_stage[k-1].g_skew.r_b;
            assign w_c_src = g_stage[k-1].r_c;
            assign w_v_src = g_stage[k-1].r_valid;
        end

        // Chunk add; the chunk of A is replaced in place by its sum.
        always_comb begin
            w_sum = SW'(w_x_src[LO +: CW]) + SW'(w_b_src[CW-1:0]) + SW'(w_c_src);
            w_x_nxt = w_x_src;
            w_x_nxt[LO +: CW] = w_sum[CW-1:0];
        end

        // Stage register: valid, carry and the merged result/operand word.
        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                r_valid <= 1'b0;
                r_c     <= 1'b0;
                r_x     <= '0;
            end else if (w_adv) begin
                r_valid <= w_v_src;
                r_c     <= w_sum[CW];
                r_x     <= w_x_nxt;
            end
        end

        // Skewed B' chunks still needed by later stages.
        if (k < LAST) begin : g_skew
            logic [BW-CW-1:0] r_b;

            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    r_b <= '0;
                end else if (w_adv) begin
                    r_b <= w_b_src[BW-1:CW];
                end
            end
        end

`ifdef ADDER_PIPE_OVF_EN
        // Signed overflow: carry into the MSB (a^b^s at the MSB) XOR carry out.
        if (k == LAST) begin : g_ovf
            logic w_cmsb;
            logic r_ovf;

            assign w_cmsb = w_x_src[WIDTH-1] ^ w_b_src[CW-1] ^ w_sum[CW-1];

            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    r_ovf <= 1'b0;
                end else if (w_adv) begin
                    r_ovf <= w_cmsb ^ w_sum[CW];
                end
            end
        end
`endif
    end

    // Outputs come straight from the last stage registers.
    assign OUT_VALID = g_stage[LAST].r_valid;
    assign Q         = g_stage[LAST].r_x;
    assign COUT      = g_stage[LAST].r_c;
`ifdef ADDER_PIPE_OVF_EN
    assign OVF       = g_stage[LAST].g_ovf.r_ovf;
`endif

endmodule

// File: tb/tb_adder_pipe_full.sv
// Testbench for adder_pipe_full (WIDTH=16, STAGES=4): directed table, stream,
// stall and reset sequences, then randomized traffic against a reference
// model that computes each result arithmetically when the operands enter.

module tb_adder_pipe_full;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned STAGES = 4;

    logic              CLK = 1'b0;
    logic              nRST;
    logic              IN_VALID;
    logic              IN_READY;
    logic [WIDTH-1:0]  A;
    logic [WIDTH-1:0]  B;
    logic              CIN;
    logic              SUB;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic [WIDTH-1:0]  Q;
    logic              COUT;
`ifdef ADDER_PIPE_OVF_EN
    logic              OVF;
`endif

    always #5 CLK = ~CLK;

    adder_pipe_full #(
        .WIDTH (WIDTH),
        .STAGES(STAGES)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .A        (A),
        .B        (B),
        .CIN      (CIN),
        .SUB      (SUB),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .Q        (Q),
`ifdef ADDER_PIPE_OVF_EN
        .OVF      (OVF),
`endif
        .COUT     (COUT)
    );

    int checks = 0;
    int errors = 0;

    // Reference pipeline occupancy: slot i holds an expected {ovf, cout, q}.
    logic        m_v [STAGES];
    logic [17:0] m_r [STAGES];

    logic [16:0] got_out [$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] q;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Plain arithmetic reference: returns {ovf, cout, q}.
    function automatic logic [17:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                           input logic cin, input logic sub);
        int ua, ub, sa, sb, r, sr;
        logic cout, ovf;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            r    = ua - ub;
            sr   = sa - sb;
            cout = (ua >= ub);
        end else begin
            r    = ua + ub + int'(cin);
            sr   = sa + sb + int'(cin);
            cout = (r > 65535);
        end
        ovf = (sr > 32767) || (sr < -32768);
        return {ovf, cout, 16'(r)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(STAGES); i++) begin
            m_v[i] = 1'b0;
            m_r[i] = '0;
        end
    endtask

    // One clock cycle: drive, check IN_READY, clock, check outputs vs model.
    task automatic step(input logic iv, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, input logic ordy);
        logic adv;
        IN_VALID  = iv;
        A         = a;
        B         = b;
        CIN       = cin;
        SUB       = sub;
        OUT_READY = ordy;
        #1;
        adv = !m_v[STAGES-1] || ordy;
        chk("in_ready", 32'(IN_READY), 32'(adv));
        if (OUT_VALID && ordy) got_out.push_back({COUT, Q});
        @(posedge CLK);
        if (adv) begin
            for (int i = int'(STAGES) - 1; i > 0; i--) begin
                m_v[i] = m_v[i-1];
                m_r[i] = m_r[i-1];
            end
            m_v[0] = iv;
            m_r[0] = ref_op(a, b, cin, sub);
        end
        #1;
        chk("out_valid", 32'(OUT_VALID), 32'(m_v[STAGES-1]));
        if (m_v[STAGES-1]) begin
            chk("q", 32'(Q), 32'(m_r[STAGES-1][15:0]));
            chk("cout", 32'(COUT), 32'(m_r[STAGES-1][16]));
`ifdef ADDER_PIPE_OVF_EN
            chk("ovf", 32'(OVF), 32'(m_r[STAGES-1][17]));
`endif
        end
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, ordy);
    endtask

    // Check that every output register reads zero right now.
    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(OUT_VALID), 32'd0);
        chk({tag, "_q"}, 32'(Q), 32'd0);
        chk({tag, "_cout"}, 32'(COUT), 32'd0);
        chk({tag, "_in_ready"}, 32'(IN_READY), 32'd1);
`ifdef ADDER_PIPE_OVF_EN
        chk({tag, "_ovf"}, 32'(OVF), 32'd0);
`endif
    endtask

    // Three back-to-back ops, optionally with OUT_READY low for two cycles.
    task automatic run_stream(input bit stall);
        logic [15:0] sa [3];
        logic [15:0] sb [3];
        logic        sc [3];
        logic [15:0] eq [3];
        logic        ec [3];
        logic        ordy;
        sa = '{16'h1234, 16'h00FF, 16'h8000};
        sb = '{16'h1111, 16'h0001, 16'h8000};
        sc = '{1'b0, 1'b1, 1'b0};
        eq = '{16'h2345, 16'h0101, 16'h0000};
        ec = '{1'b0, 1'b0, 1'b1};
        got_out.delete();
        for (int i = 0; i < 10; i++) begin
            ordy = !(stall && (i == 4 || i == 5));
            if (i < 3) step(1'b1, sa[i], sb[i], sc[i], 1'b0, ordy);
            else       step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, ordy);
            if (!stall && i >= 3 && i <= 5) begin
                chk("stream_valid", 32'(OUT_VALID), 32'd1);
                chk("stream_q", 32'(Q), 32'(eq[i-3]));
                chk("stream_cout", 32'(COUT), 32'(ec[i-3]));
            end
            if (stall && i >= 3 && i <= 5) begin
                chk("stall_hold_valid", 32'(OUT_VALID), 32'd1);
                chk("stall_hold_q", 32'(Q), 32'h2345);
            end
        end
        chk("stream_count", 32'(got_out.size()), 32'd3);
        for (int j = 0; j < 3 && j < got_out.size(); j++)
            chk("stream_order", 32'(got_out[j]), 32'({ec[j], eq[j]}));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] corners [6];
        logic [15:0] ra, rb;

        corners = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h00FF};

        //         a         b        cin   sub   q         cout  ovf
        tbl[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[2]  = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
        tbl[3]  = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
        tbl[4]  = '{16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0};
        tbl[5]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[6]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        tbl[7]  = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        tbl[8]  = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[9]  = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0};
        tbl[10] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[11] = '{16'hABCD, 16'h0000, 1'b0, 1'b1, 16'hABCD, 1'b1, 1'b0};
        tbl[12] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[13] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[14] = '{16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0};

        // Power-on reset
        nRST = 1'b0; IN_VALID = 1'b0; A = '0; B = '0; CIN = 1'b0; SUB = 1'b0; OUT_READY = 1'b0;
        model_reset();
        #2;
        chk_zero("reset");
        @(posedge CLK); @(posedge CLK); #1;
        nRST = 1'b1;

        // Directed table: one op at a time, exact latency, single-cycle valid
        for (int i = 0; i < 15; i++) begin
            step(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, 1'b1);
            for (int j = 1; j < int'(STAGES); j++) begin
                chk("tbl_early_valid", 32'(OUT_VALID), 32'd0);
                idle(1'b1);
            end
            chk("tbl_latency", 32'(OUT_VALID), 32'd1);
            chk("tbl_q", 32'(Q), 32'(tbl[i].q));
            chk("tbl_cout", 32'(COUT), 32'(tbl[i].cout));
`ifdef ADDER_PIPE_OVF_EN
            chk("tbl_ovf", 32'(OVF), 32'(tbl[i].ovf));
`endif
            idle(1'b1);
            chk("tbl_one_cycle", 32'(OUT_VALID), 32'd0);
        end

        run_stream(1'b0);
        run_stream(1'b1);

        // Reset while two ops are in flight: nothing emerges afterwards
        step(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h0F0F, 16'h0101, 1'b0, 1'b1, 1'b1);
        nRST = 1'b0;
        IN_VALID = 1'b0;
        #1;
        chk_zero("midrst");
        model_reset();
        @(posedge CLK); #1;
        chk_zero("midrst_hold");
        nRST = 1'b1;
        got_out.delete();
        for (int i = 0; i < 8; i++) idle(1'b1);
        chk("midrst_no_output", 32'(got_out.size()), 32'd0);

        // Reset while a result is held at the output: cleared asynchronously
        step(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < int'(STAGES); i++) idle(1'b0);
        chk("held_valid", 32'(OUT_VALID), 32'd1);
        chk("held_q", 32'(Q), 32'h2345);
        #2;
        nRST = 1'b0;
        #1;
        chk_zero("heldrst");
        model_reset();
        @(posedge CLK); #1;
        nRST = 1'b1;
        idle(1'b1);

        // Randomized traffic with random back-pressure and mixed add/sub
        for (int i = 0; i < 500; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
            step(1'($urandom_range(0, 99) < 70), ra, rb, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < 70));
        end
        for (int i = 0; i < int'(STAGES) + 2; i++) idle(1'b1);
        chk("drain_empty", 32'(OUT_VALID), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
